// File: rtl/router_1xn_core.sv
// 1-to-N byte-serial packet router core.
// A header-decoding FSM steers each packet into one of NUM_PORTS destination
// FIFOs, applies backpressure through busy, checks the trailing parity byte
// and silently discards packets carrying an illegal address. Each destination
// FIFO is flushed after TIMEOUT idle cycles holding unread data.
module router_1xn_core #(
  parameter int DATA_W     = 8,
  parameter int NUM_PORTS  = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        pkt_valid,
  output logic                        busy,
  output logic                        error,
  input  logic [NUM_PORTS-1:0]        read_enb,
  output logic [NUM_PORTS-1:0]        valid_out,
  output logic [NUM_PORTS*DATA_W-1:0] data_out
);

  localparam int ADDR_W = 2;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_DATA,
    LOAD_PARITY,
    CHECK_PARITY,
    DROP
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   parity_calc;
  logic [DATA_W-1:0]   parity_rx;

  logic [ADDR_W-1:0]   hdr_addr;
  logic                hdr_legal;
  logic [3:0]          full_pad;
  logic [NUM_PORTS-1:0] full;

  logic                wr_any;
  logic [ADDR_W-1:0]   wr_port;
  logic [DATA_W-1:0]   wr_data;
  logic [NUM_PORTS-1:0] wr_en;
  logic                hdr_take;
  logic                payload_take;
  logic                parity_take;

  // The length field is informational: the pkt_valid fall delimits a packet,
  // so only the address bits of the header steer the FSM.
  assign hdr_addr  = data_in[ADDR_W-1:0];
  assign hdr_legal = (32'(hdr_addr) < NUM_PORTS);

  // Pad the full flags to the full address range so any 2-bit index is legal.
  always_comb begin
    full_pad                = '0;
    full_pad[NUM_PORTS-1:0] = full;
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the order of statements does not matter.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state, busy and FIFO write steering.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_next   = state;
    busy         = 1'b0;
    wr_any       = 1'b0;
    wr_port      = addr_q;
    wr_data      = data_in;
    hdr_take     = 1'b0;
    payload_take = 1'b0;
    parity_take  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pkt_valid) begin
          if (!hdr_legal) begin
            state_next = DROP;
          end else if (full_pad[hdr_addr]) begin
            busy = 1'b1;
          end else begin
            wr_any     = 1'b1;
            wr_port    = hdr_addr;
            hdr_take   = 1'b1;
            state_next = LOAD_DATA;
          end
        end
      end
      LOAD_DATA: begin
        if (full_pad[addr_q]) begin
          busy = 1'b1;
        end else if (pkt_valid) begin
          wr_any       = 1'b1;
          payload_take = 1'b1;
        end else begin
          // The parity byte is taken from the source here but only written
          // to the FIFO from its holding register in LOAD_PARITY.
          parity_take = 1'b1;
          state_next  = LOAD_PARITY;
        end
      end
      LOAD_PARITY: begin
        if (full_pad[addr_q]) begin
          busy = 1'b1;
        end else begin
          wr_any     = 1'b1;
          wr_data    = parity_rx;
          state_next = CHECK_PARITY;
        end
      end
      CHECK_PARITY: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      DROP: begin
        if (!pkt_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Packet context: destination, running parity, received parity, error pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q      <= '0;
      parity_calc <= '0;
      parity_rx   <= '0;
      error       <= 1'b0;
    end else begin
      error <= (state == CHECK_PARITY) && (parity_rx != parity_calc);
      if (hdr_take) begin
        addr_q      <= hdr_addr;
        parity_calc <= data_in;
      end
      if (payload_take) parity_calc <= parity_calc ^ data_in;
      if (parity_take)  parity_rx   <= data_in;
    end
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [TO_W-1:0]   idle_cnt;
    logic [DATA_W-1:0] dout;
    logic              flush;
    logic              do_wr;
    logic              do_rd;

    assign wr_en[k]  = wr_any && (wr_port == ADDR_W'(k));
    assign full[k]   = (count == CNT_W'(FIFO_DEPTH));
    assign flush     = (idle_cnt == TO_W'(TIMEOUT));
    // A flush wins over both a simultaneous write and a simultaneous read.
    assign do_wr     = wr_en[k] && !flush;
    assign do_rd     = read_enb[k] && (count != '0) && !flush;

    assign valid_out[k]                  = (count != '0);
    assign data_out[k*DATA_W +: DATA_W]  = dout;

    // Storage array, written at the tail.
    always_ff @(posedge clock) begin
      // NOTE: the storage array has no reset; emptiness is defined by the
      // pointers and count alone, so stale contents are never observable.
      if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers, occupancy, registered read data and idle timeout counter.
    always_ff @(posedge clock) begin
      if (reset) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        idle_cnt <= '0;
        dout     <= '0;
      end else if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        idle_cnt <= '0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + 1'b1;
        if (do_rd) begin
          rd_ptr <= rd_ptr + 1'b1;
          dout   <= mem[rd_ptr];
        end
        count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
        if (read_enb[k] || (count == '0)) idle_cnt <= '0;
        else                              idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule
